// File: rtl/sar_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : sar_scan_controller
// Description : Multi-channel successive-approximation ADC scan sequencer.
//               Drives the analog mux select, S/H strobe and DAC trial code.
//               It walks the set bits of a latched channel mask, converting
//               each enabled channel in turn, once or continuously.
//               Build macro SAR_AVG_EN adds per-channel oversampling.
//               With it, 2^AVG_LOG2 conversions are averaged per channel.
// Revision    : 1.0 - initial release
// ============================================================================
module sar_scan_controller #(
  parameter int WIDTH      = 8,
  parameter int NCH        = 4,
  parameter int SAMPLE_CYC = 2,
  parameter int AVG_LOG2   = 2,
  localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             continuous,
  input  logic [NCH-1:0]   ch_mask,
  input  logic             cmp,
  output logic             sample,
  output logic [CH_W-1:0]  ch_sel,
  output logic [WIDTH-1:0] value,
  output logic             valid,
  output logic [WIDTH-1:0] result,
  output logic [CH_W-1:0]  result_ch,
  output logic             busy
);

  localparam int SCNT_W = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SAMPLE  = 2'd1,
    S_CONVERT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NCH-1:0]    mask_q, mask_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [WIDTH-1:0]  approx_q, approx_d;
  logic [WIDTH-1:0]  bitm_q, bitm_d;      // one-hot bit under trial
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [CH_W-1:0]   result_ch_q, result_ch_d;
  logic              valid_q, valid_d;

  logic [WIDTH-1:0]  trial;
  logic [WIDTH-1:0]  conv;
  logic [CH_W:0]     nxt;                 // {found, index}
  logic              last_conv;

`ifdef SAR_AVG_EN
  localparam int REP_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int NREP  = 1 << AVG_LOG2;
  localparam int ACC_W = WIDTH + AVG_LOG2;

  logic [REP_W-1:0]  rep_q, rep_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [ACC_W-1:0]  acc_sum;
`else
  logic unused_avg;
  assign unused_avg = (AVG_LOG2 != 0);
`endif

  // Lowest set bit of a mask (caller guarantees the mask is non-zero).
  function automatic logic [CH_W-1:0] lowest_ch(input logic [NCH-1:0] m);
    lowest_ch = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) lowest_ch = CH_W'(i);
    end
  endfunction

  // Next set bit strictly above cur; MSB of the return flags that one exists.
  function automatic logic [CH_W:0] next_ch(input logic [NCH-1:0] m,
                                            input logic [CH_W-1:0] cur);
    next_ch = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i] && (i > int'(cur))) next_ch = {1'b1, CH_W'(i)};
    end
  endfunction

  // Next-state and datapath update for the scan / conversion sequencer.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    ch_d        = ch_q;
    approx_d    = approx_q;
    bitm_d      = bitm_q;
    scnt_d      = scnt_q;
    result_d    = result_q;
    result_ch_d = result_ch_q;
    valid_d     = 1'b0;
    trial       = approx_q | bitm_q;
    conv        = cmp ? trial : approx_q;
    nxt         = next_ch(mask_q, ch_q);
`ifdef SAR_AVG_EN
    rep_d       = rep_q;
    acc_d       = acc_q;
    // The first repeat starts from zero, so the accumulator needs no clear pass.
    acc_sum     = ((rep_q == '0) ? '0 : acc_q) + ACC_W'(conv);
    last_conv   = (rep_q == REP_W'(NREP - 1));
`else
    last_conv   = 1'b1;
`endif

    case (state_q)
      S_IDLE: begin
        if (go && (ch_mask != '0)) begin
          mask_d  = ch_mask;
          ch_d    = lowest_ch(ch_mask);
          scnt_d  = '0;
          state_d = S_SAMPLE;
`ifdef SAR_AVG_EN
          rep_d   = '0;
`endif
        end
      end

      S_SAMPLE: begin
        if (scnt_q == SCNT_W'(SAMPLE_CYC - 1)) begin
          state_d  = S_CONVERT;
          approx_d = '0;
          bitm_d   = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
          scnt_d   = scnt_q + 1'b1;
        end
      end

      S_CONVERT: begin
        approx_d = conv;
        bitm_d   = bitm_q >> 1;
        if (bitm_q[0]) begin
          scnt_d  = '0;
          state_d = S_SAMPLE;
          if (last_conv) begin
            valid_d     = 1'b1;
            result_ch_d = ch_q;
`ifdef SAR_AVG_EN
            result_d    = WIDTH'(acc_sum >> AVG_LOG2);
            acc_d       = acc_sum;
            rep_d       = '0;
`else
            result_d    = conv;
`endif
            if (nxt[CH_W]) begin
              ch_d    = nxt[CH_W-1:0];
            end else if (continuous) begin
              ch_d    = lowest_ch(mask_q);
            end else begin
              state_d = S_IDLE;
            end
          end
`ifdef SAR_AVG_EN
          else begin
            rep_d = rep_q + 1'b1;
            acc_d = acc_sum;
          end
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously by the reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      ch_q        <= '0;
      approx_q    <= '0;
      bitm_q      <= '0;
      scnt_q      <= '0;
      result_q    <= '0;
      result_ch_q <= '0;
      valid_q     <= 1'b0;
`ifdef SAR_AVG_EN
      rep_q       <= '0;
      acc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      ch_q        <= ch_d;
      approx_q    <= approx_d;
      bitm_q      <= bitm_d;
      scnt_q      <= scnt_d;
      result_q    <= result_d;
      result_ch_q <= result_ch_d;
      valid_q     <= valid_d;
`ifdef SAR_AVG_EN
      rep_q       <= rep_d;
      acc_q       <= acc_d;
`endif
    end
  end

  assign sample    = (state_q == S_SAMPLE);
  assign value     = (state_q == S_CONVERT) ? trial : '0;
  assign busy      = (state_q != S_IDLE);
  assign ch_sel    = ch_q;
  assign valid     = valid_q;
  assign result    = result_q;
  assign result_ch = result_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_sar_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sar_scan_controller
// Description : Scoreboard bench for sar_scan_controller. Expected results
//               are queued when a scan is started, and a monitor pops and
//               compares them on every valid pulse. Build macro SAR_AVG_EN
//               selects the averaging scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sar_scan_controller;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int CH_W  = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             go = 1'b0;
  logic             continuous = 1'b0;
  logic [NCH-1:0]   ch_mask = '0;
  logic             cmp = 1'b0;
  logic             sample;
  logic [CH_W-1:0]  ch_sel;
  logic [WIDTH-1:0] value;
  logic             valid;
  logic [WIDTH-1:0] result;
  logic [CH_W-1:0]  result_ch;
  logic             busy;

  sar_scan_controller #(
    .WIDTH(WIDTH), .NCH(NCH), .SAMPLE_CYC(2), .AVG_LOG2(2)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .continuous(continuous),
    .ch_mask(ch_mask), .cmp(cmp), .sample(sample), .ch_sel(ch_sel),
    .value(value), .valid(valid), .result(result), .result_ch(result_ch),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic [CH_W-1:0]  ch;
    int               at;
  } exp_t;
  exp_t sb[$];

  logic [WIDTH-1:0] ain [NCH];
  logic [WIDTH-1:0] avg_tbl [4] = '{8'd100, 8'd101, 8'd102, 8'd103};
  bit               use_avg_tbl = 1'b0;
  int               conv_idx = -1;
  logic             prev_sample = 1'b0;
  logic [WIDTH-1:0] vals[$];
  int               samp_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic push_exp(input logic [WIDTH-1:0] r, input logic [CH_W-1:0] c,
                          input int at);
    exp_t e;
    e.res = r;
    e.ch  = c;
    e.at  = at;
    sb.push_back(e);
  endtask

  // Analog front-end model plus trace recording.
  always @(negedge clk) begin
    if (sample && !prev_sample) conv_idx++;
    prev_sample = sample;
    if (use_avg_tbl && conv_idx >= 0 && conv_idx < 4)
      cmp = (avg_tbl[conv_idx] >= value);
    else
      cmp = (ain[ch_sel] >= value);
    if (value != '0) vals.push_back(value);
    if (sample) samp_cnt++;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (rst && valid) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_valid: result %0d ch %0d with nothing queued",
                 result, result_ch);
      end else begin
        e = sb.pop_front();
        check("result", int'(result), int'(e.res));
        check("result_ch", int'(result_ch), int'(e.ch));
        if (e.at >= 0) check("valid_cycle", cyc, e.at);
      end
    end
  end

  task automatic clear_trace();
    vals.delete();
    samp_cnt = 0;
  endtask

  task automatic pulse_go(output int e0);
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    #1 e0 = cyc;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int exp_cyc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 300);
    if (busy) begin
      total++;
      $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, n);
    end else begin
      check(name, cyc, exp_cyc);
    end
  endtask

  task automatic check_vals167(input string tag);
    logic [WIDTH-1:0] exp_v [8] = '{8'd128, 8'd192, 8'd160, 8'd176,
                                    8'd168, 8'd164, 8'd166, 8'd167};
    check({tag, "_nvals"}, vals.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < vals.size()) check($sformatf("%s_value%0d", tag, i),
                                 int'(vals[i]), int'(exp_v[i]));
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_sample"}, int'(sample), 0);
    check({tag, "_ch_sel"}, int'(ch_sel), 0);
    check({tag, "_value"}, int'(value), 0);
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_result"}, int'(result), 0);
    check({tag, "_result_ch"}, int'(result_ch), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0;
    for (int i = 0; i < NCH; i++) ain[i] = '0;
    #2 rst = 1'b0;
    #1 check_outputs_zero("reset");
    #20 rst = 1'b1;

`ifdef SAR_AVG_EN
    // Four repeats on channel 0 with inputs 100..103 -> 406 >> 2 = 101.
    use_avg_tbl = 1'b1;
    conv_idx    = -1;
    ch_mask     = 4'b0001;
    clear_trace();
    pulse_go(e0);
    push_exp(8'd101, 2'd0, e0 + 40);
    wait_idle("avg_done_cycle", e0 + 40);
    check("avg_sample_cycles", samp_cnt, 8);
`else
    // Single channel 0, input 167.
    ain[0]  = 8'd167;
    ch_mask = 4'b0001;
    clear_trace();
    pulse_go(e0);
    push_exp(8'd167, 2'd0, e0 + 10);
    wait_idle("single_idle_cycle", e0 + 10);
    check("single_sample_cycles", samp_cnt, 2);
    check_vals167("single");

    // Two-channel scan, no gap, busy drops with the second valid.
    ain[1]  = 8'd0;
    ain[3]  = 8'd255;
    ch_mask = 4'b1010;
    pulse_go(e0);
    push_exp(8'd0,   2'd1, e0 + 10);
    push_exp(8'd255, 2'd3, e0 + 20);
    wait_idle("scan_idle_cycle", e0 + 20);

    // Continuous scan of channels 0 and 2; drop continuous during scan 3.
    ain[0]     = 8'd50;
    ain[2]     = 8'd200;
    ch_mask    = 4'b0101;
    continuous = 1'b1;
    pulse_go(e0);
    for (int k = 0; k < 3; k++) begin
      push_exp(8'd50,  2'd0, e0 + 20 * k + 10);
      push_exp(8'd200, 2'd2, e0 + 20 * k + 20);
    end
    while (cyc < e0 + 45) @(negedge clk);
    continuous = 1'b0;
    wait_idle("cont_idle_cycle", e0 + 60);

    // go with an empty mask is ignored.
    ch_mask = 4'b0000;
    pulse_go(e0);
    @(negedge clk);
    check("mask0_busy", int'(busy), 0);
    check("mask0_sample", int'(sample), 0);

    // go pulsed mid-conversion neither restarts nor relatches the mask.
    ain[0]  = 8'd167;
    ch_mask = 4'b0001;
    clear_trace();
    pulse_go(e0);
    push_exp(8'd167, 2'd0, e0 + 10);
    while (cyc < e0 + 5) @(negedge clk);
    go      = 1'b1;
    ch_mask = 4'b1111;
    @(negedge clk);
    go      = 1'b0;
    ch_mask = 4'b0001;
    wait_idle("midgo_idle_cycle", e0 + 10);
    check_vals167("midgo");

    // Asynchronous reset during CONVERT bit 4 of channel 2.
    ain[2]  = 8'd167;
    ch_mask = 4'b0100;
    pulse_go(e0);
    while (cyc < e0 + 6) @(negedge clk);
    check("pre_reset_ch_sel", int'(ch_sel), 2);
    #2 rst = 1'b0;
    #1 check_outputs_zero("midreset");
    @(negedge clk);
    rst = 1'b1;

    // Fresh conversion after reset release.
    ch_mask = 4'b0001;
    clear_trace();
    pulse_go(e0);
    push_exp(8'd167, 2'd0, e0 + 10);
    wait_idle("post_reset_idle_cycle", e0 + 10);
    check_vals167("post_reset");
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sar_scan_controller.md
Name: sar_scan_controller

Overview:
- Parametrised successor to the 8-bit single-shot SAR controller.
- Generic resolution, multi-channel scan sequencer driving an external analog mux, programmable sample/hold time, single-scan or continuous mode.
- Sits between the control logic (go/mask) and the analog front-end (mux select, S/H, DAC, comparator).
- Optional oversampling/averaging is compiled in by macro.

Parameters:
- WIDTH, 8: conversion resolution in bits (>=2).
- NCH, 4: number of analog channels (>=1). Localparam CH_W = max(1, clog2(NCH)).
- SAMPLE_CYC, 2: cycles `sample` is held high per conversion (>=1).
- AVG_LOG2, 2: log2 of conversions averaged per channel; used only with SAR_AVG_EN.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- go  in  1  start-scan request, sampled on a rising edge.
- continuous  in  1  1 = restart the scan after the last channel; sampled live at the end of each scan.
- ch_mask  in  NCH  enabled channels, latched when go is accepted.
- cmp  in  1  comparator output: 1 = analog input >= value.
- sample  out  1  S/H control, high during the SAMPLE phase.
- ch_sel  out  CH_W  analog mux select, i.e. the channel currently being converted.
- value  out  WIDTH  DAC trial code.
- valid  out  1  one-cycle pulse when result/result_ch are updated.
- result  out  WIDTH  last conversion result, held until the next update.
- result_ch  out  CH_W  channel index of `result`.
- busy  out  1  high from go acceptance until the scan completes.

Behaviour:
- Reset (rst=0, asynchronous, effective at any point including mid-conversion): state IDLE. All outputs 0: sample, ch_sel, value, valid, result, result_ch, busy. Latched mask cleared.
- States: IDLE -> SAMPLE -> CONVERT -> (SAMPLE of next channel | IDLE).
- IDLE:
  - go=1 with ch_mask!=0: latch the mask, ch_sel = lowest set bit, busy=1, enter SAMPLE.
  - go=1 with ch_mask==0: ignored, stay IDLE.
- SAMPLE: sample=1, value=0, for exactly SAMPLE_CYC cycles. Then enter CONVERT with value = 1<<(WIDTH-1) and the approximation register cleared.
- CONVERT: lasts exactly WIDTH cycles. Cycle k (k=0..WIDTH-1) presents value = approx | (1<<(WIDTH-1-k)).
  - At the rising edge ending cycle k: if cmp=1, that bit is kept in approx; otherwise it is dropped.
  - cmp is used only in CONVERT and ignored elsewhere.
- Completion: on the edge ending the last CONVERT cycle, result <= final approx and result_ch <= ch_sel. valid is high for the following single cycle. value returns to 0.
- Latency: go accepted on edge E0 -> valid high in the cycle after edge E0+SAMPLE_CYC+WIDTH.
- Sequencing: after each conversion, move to the next higher set bit of the latched mask and go directly to SAMPLE; there is no IDLE gap.
- End of scan: when there is no higher set bit:
  - continuous=1: wrap to the lowest set bit and re-enter SAMPLE.
  - continuous=0: enter IDLE, busy=0 in the same cycle valid is high.
- go while busy=1 is ignored. ch_mask changes while busy have no effect.
- A channel enabled in the mask is never skipped. Unset channels are never selected. NCH=1 always selects channel 0.

Optional Feature:
- Macro SAR_AVG_EN.
- Defined:
  - Each selected channel is converted 2^AVG_LOG2 times back-to-back, each with its own SAMPLE phase; ch_sel is unchanged across these repeats.
  - Results are summed in a (WIDTH+AVG_LOG2)-bit accumulator, cleared at the first repeat.
  - After the last repeat: result = accumulator >> AVG_LOG2 (truncated) and valid pulses once. No valid pulse occurs for intermediate conversions.
  - Per-channel latency = 2^AVG_LOG2 * (SAMPLE_CYC+WIDTH) cycles.
- Undefined: one conversion per channel; AVG_LOG2 is ignored; no accumulator is present.

Test Plan:
- Single channel, defaults: ch_mask=0001, cmp modeled as (167 >= value) at negedge, go pulse.
  - Required: sample high 2 cycles.
  - Required: value sequence 128,192,160,176,168,164,166,167.
  - Required: result=167, result_ch=0, valid one cycle at go-edge+10, then busy=0.
- Scan: ch_mask=1010, ch1 input=0, ch3 input=255, continuous=0.
  - Required: valid with result=0/result_ch=1, then result=255/result_ch=3.
  - Required: no IDLE gap between the two conversions; busy falls with the second valid.
- Continuous: ch_mask=0101, continuous=1 for 3 scans, then drop continuous to 0.
  - Required: result_ch sequence 0,2,0,2,0,2...
  - Required: the scan in progress completes on channel 2, then IDLE.
- Ignored requests:
  - go with ch_mask=0 -> busy stays 0.
  - go pulsed mid-conversion -> no restart; the value sequence is unaffected.
- Reset mid-CONVERT (rst=0 at bit 4 of 8): all outputs 0 immediately, asynchronously. After release, a new go converts correctly (result=167).
- SAR_AVG_EN, AVG_LOG2=2: inputs 100,101,102,103 on successive repeats.
  - Required: exactly one valid with result=101 (406>>2).
  - Required: valid at 4*(2+8) cycles after go.
